// File: rtl/loa_accumulator.sv
// loa_accumulator: partial-sum accumulator wrapped around an external 32-bit
// lower-part-OR approximate adder. The running sum is fed back as adder operand A,
// the streamed operand is operand B, and the adder result is captured on each
// input handshake. The final sum is returned on a valid/ready output.
//
// Optional feature: define LOA_ACC_SAT_EN to make the accumulator saturate to all
// ones on the first adder carry-out of a job. Without it the sum wraps and only
// out_ovf_o reports the overflow.
`timescale 1ns/1ps

module loa_accumulator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_terms_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    output logic             add_cin_o,
    input  logic [WIDTH-1:0] add_sum_i,
    input  logic             add_cout_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             hs;
`ifdef LOA_ACC_SAT_EN
    logic             sat_q, sat_d;
`endif

    // in_ready_q is only ever set in StAcc, so it doubles as the state qualifier.
    assign hs = in_valid_i & in_ready_q;

    // Adder port wiring: operands are driven continuously, carry-in is unused.
    assign add_a_o     = acc_q;
    assign add_b_o     = in_data_i;
    assign add_cin_o   = 1'b0;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = acc_q;
    assign out_ovf_o   = ovf_q;
    assign busy_o      = busy_q;

    // Next accumulator/overflow values, applied only on a handshake.
    always_comb begin
        acc_d = add_sum_i;
        ovf_d = ovf_q | add_cout_i;
`ifdef LOA_ACC_SAT_EN
        sat_d = sat_q;
        if (sat_q) begin
            acc_d = acc_q;
        end else if (add_cout_i) begin
            acc_d = '1;
            sat_d = 1'b1;
        end
`endif
    end

    // Job FSM with registered handshake/status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef LOA_ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        cnt_q  <= num_terms_i;
                        busy_q <= 1'b1;
`ifdef LOA_ACC_SAT_EN
                        sat_q  <= 1'b0;
`endif
                        if (num_terms_i != '0) begin
                            state_q    <= StAcc;
                            in_ready_q <= 1'b1;
                        end else begin
                            // Empty job: report a zero result immediately.
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StAcc: begin
                    if (hs) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_q - CNT_W'(1);
`ifdef LOA_ACC_SAT_EN
                        sat_q <= sat_d;
`endif
                        if (cnt_q == CNT_W'(1)) begin
                            state_q     <= StDone;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loa_accumulator.sv
// Bench for loa_accumulator with a behavioural 24/8 lower-part-OR adder attached.
// Stimulus pushes expected results into a queue; a negedge monitor checks them.
`timescale 1ns/1ps

module tb_loa_accumulator;

    typedef struct {
        logic [31:0] d;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_terms = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        busy;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // 24/8 LOA adder: low byte is OR, upper 24 bits add with carry-in a[7]&b[7].
    function automatic logic [32:0] loa_add(input logic [31:0] a, input logic [31:0] b);
        logic [24:0] hi;
        hi = {1'b0, a[31:8]} + {1'b0, b[31:8]} + {24'd0, a[7] & b[7]};
        return {hi, a[7:0] | b[7:0]};
    endfunction

    assign {add_cout, add_sum} = loa_add(add_a, add_b);

    loa_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .num_terms_i (num_terms),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_cin_o   (add_cin),
        .add_sum_i   (add_sum),
        .add_cout_i  (add_cout),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ovf_o   (out_ovf),
        .busy_o      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: fold the operand list through the approximate adder.
    function automatic exp_t model(input logic [31:0] ops[$]);
        exp_t        r;
        logic [32:0] s;
        bit          sat;
        r.d = '0;
        r.o = 1'b0;
        sat = 1'b0;
        foreach (ops[i]) begin
            s = loa_add(r.d, ops[i]);
            r.o = r.o | s[32];
`ifdef LOA_ACC_SAT_EN
            if (!sat) begin
                if (s[32]) begin
                    r.d = '1;
                    sat = 1'b1;
                end else begin
                    r.d = s[31:0];
                end
            end
`else
            r.d = s[31:0];
`endif
        end
        return r;
    endfunction

    // Monitor: whenever a result is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_ovf", 32'(out_ovf), 32'(exp_q[0].o));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // mode: 0 always valid, 1 alternating valid, 2 random valid.
    task automatic run_job(input int n, input logic [31:0] ops[$], input int mode,
                           input int hold, input bit lit, input logic [31:0] ld,
                           input bit lo, input bit poke);
        exp_t e;
        int   idx;
        int   cyc;
        bit   v;
        bit   hs;
        if (lit) begin
            e.d = ld;
            e.o = lo;
        end else begin
            e = model(ops);
        end
        exp_q.push_back(e);
        start = 1'b1;
        num_terms = 8'(n);
        tick();
        start = 1'b0;
        num_terms = '0;
        chk("busy_after_start", 32'(busy), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom);
            endcase
            in_valid = v;
            in_data = v ? ops[idx] : $urandom;
            // A start issued mid-job must not reload the counter.
            start = poke && (cyc == 1);
            num_terms = start ? 8'd1 : 8'd0;
            hs = v && in_ready;
            tick();
            cyc++;
            if (hs) idx++;
        end
        start = 1'b0;
        num_terms = '0;
        in_valid = 1'b0;
        if (idx < n) begin
            chk("operand_timeout", 32'(idx), 32'(n));
            exp_q.delete();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            return;
        end
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("out_valid_held", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ops[$];
        logic [31:0] ovf_exp;
        rst_n = 1'b0;
        repeat (2) tick();
        chk_reset_vals();
        rst_n = 1'b1;
        tick();

        ops = {32'd3, 32'd5};
        run_job(2, ops, 0, 0, 1'b1, 32'h7, 1'b0, 1'b0);
        ops = {32'h80, 32'h80};
        run_job(2, ops, 0, 1, 1'b1, 32'h180, 1'b0, 1'b0);
`ifdef LOA_ACC_SAT_EN
        ovf_exp = 32'hFFFF_FFFF;
`else
        ovf_exp = 32'h00FF_FF00;
`endif
        ops = {32'hFFFF_FF00, 32'h0100_0000};
        run_job(2, ops, 0, 0, 1'b1, ovf_exp, 1'b1, 1'b0);
        ops = {32'h0000_1111, 32'h0000_2202, 32'h0003_0030};
        run_job(3, ops, 1, 4, 1'b0, '0, 1'b0, 1'b0);
        ops = {32'h10, 32'h20, 32'h40};
        run_job(3, ops, 0, 0, 1'b1, 32'h70, 1'b0, 1'b1);
        ops = {};
        run_job(0, ops, 0, 0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Mid-job reset: partial sum discarded, no result produced.
        start = 1'b1;
        num_terms = 8'd4;
        tick();
        start = 1'b0;
        num_terms = '0;
        in_valid = 1'b1;
        in_data = 32'h1234;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("post_reset_no_valid", 32'(out_valid), 32'd0);
        end
        ops = {32'h2A};
        run_job(1, ops, 0, 0, 1'b1, 32'h2A, 1'b0, 1'b0);

        // Randomized jobs checked against the reference fold.
        repeat (25) begin
            int n;
            n = $urandom_range(1, 6);
            ops = {};
            for (int i = 0; i < n; i++) begin
                ops.push_back(($urandom_range(0, 3) == 0) ? $urandom
                                                          : ($urandom & 32'h00FF_FFFF));
            end
            run_job(n, ops, 2, $urandom_range(0, 3), 1'b0, '0, 1'b0, 1'b0);
        end

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
